// File: rtl/mem_port_arbiter.sv
// Shares one single-port main-memory interface between instruction fetch (IF)
// and data load/store (D); D has priority with an anti-starvation limit for IF.
module mem_port_arbiter #(
    parameter int unsigned DATA_STREAK_MAX = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 16
) (
    input  logic        SYS_clk,
    input  logic        SYS_reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam int unsigned STREAK_W = $clog2(DATA_STREAK_MAX + 1);
    localparam int unsigned TO_W     = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    logic [1:0]          state;
    logic [1:0]          state_n;
    logic                owner_d;
    logic                owner_d_n;
    logic [STREAK_W-1:0] streak;
    logic [TO_W-1:0]     to_cnt;
    logic                choose_d;
    logic                choose_if;
    logic                sel;
    logic                gnt;
    logic                rsp_valid;
    logic                rsp_err;
    logic [31:0]         rsp_data;

    // D wins unless it has hogged the port while IF was waiting
    assign choose_d  = d_req && ((streak < STREAK_W'(DATA_STREAK_MAX)) || !if_req);
    assign choose_if = !choose_d && if_req;

    // Next-state, owner selection and transaction-completion decode
    always_comb begin
        state_n   = state;
        owner_d_n = owner_d;
        sel       = 1'b0;
        gnt       = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_data  = '0;
        case (state)
            ST_IDLE: begin
                if (choose_d) begin
                    owner_d_n = 1'b1;
                    sel       = 1'b1;
                    state_n   = ST_REQ;
                end else if (choose_if) begin
                    owner_d_n = 1'b0;
                    sel       = 1'b1;
                    state_n   = (if_addr[1:0] != 2'b00) ? ST_ERR : ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    gnt     = 1'b1;
                    state_n = mem_we ? ST_IDLE : ST_RESP;
                end
            end
            ST_RESP: begin
                if (mem_rvalid) begin
                    rsp_valid = 1'b1;
                    rsp_data  = mem_rdata;
                    state_n   = ST_IDLE;
                end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    rsp_valid = 1'b1;
                    rsp_err   = 1'b1;
                    state_n   = ST_IDLE;
                end
            end
            ST_ERR: begin
                rsp_valid = 1'b1;
                rsp_err   = 1'b1;
                state_n   = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Handshake outputs are suppressed while reset is asserted so nothing in flight leaks out
    assign if_gnt    = !SYS_reset && gnt && !owner_d;
    assign d_gnt     = !SYS_reset && gnt && owner_d;
    assign if_rvalid = !SYS_reset && rsp_valid && !owner_d;
    assign d_rvalid  = !SYS_reset && rsp_valid && owner_d;
    assign if_err    = if_rvalid && rsp_err;
    assign d_err     = d_rvalid && rsp_err;
    assign if_rdata  = if_rvalid ? rsp_data : 32'h0;
    assign d_rdata   = d_rvalid ? rsp_data : 32'h0;
    assign mem_req   = !SYS_reset && (state == ST_REQ);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            state   <= ST_IDLE;
            owner_d <= 1'b0;
        end else begin
            state   <= state_n;
            owner_d <= owner_d_n;
        end
    end

    // Memory request payload captured at arbitration and held through the stall
    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else if (sel) begin
            if (owner_d_n) begin
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                mem_wstrb <= d_wstrb;
            end else begin
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
                mem_wstrb <= '0;
            end
        end
    end

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            to_cnt <= '0;
        end else if ((state == ST_REQ) && mem_ack) begin
            to_cnt <= '0;
        end else if ((state == ST_RESP) && !mem_rvalid) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Saturating count of D grants taken while IF was waiting
    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            streak <= '0;
        end else if ((gnt && !owner_d) || (state == ST_ERR) || ((state == ST_IDLE) && !if_req)) begin
            streak <= '0;
        end else if (gnt && owner_d && if_req && (streak < STREAK_W'(DATA_STREAK_MAX))) begin
            streak <= streak + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected responses are queued when a
// grant is issued and popped when the arbiter returns rvalid.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        is_d;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        SYS_clk = 1'b0;
    logic        SYS_reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        busy;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    mem_port_arbiter dut (
        .SYS_clk    (SYS_clk),
        .SYS_reset  (SYS_reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .if_err     (if_err),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_wstrb    (d_wstrb),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .d_err      (d_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ack    (mem_ack),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    always #5 SYS_clk = ~SYS_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change 2 time units after the rising edge; checks follow #1 later
    task automatic tick();
        @(posedge SYS_clk);
        #2;
    endtask

    task automatic test_reset();
        SYS_reset = 1'b1;
        tick();
        tick();
        SYS_reset = 1'b0;
        #1;
        total++;
        if ({if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err, mem_req, mem_we, busy} !== 9'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 000000000",
                     {if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err, mem_req, mem_we, busy});
        end
        total++;
        if ({mem_addr, mem_wdata, mem_wstrb, if_rdata, d_rdata} !== 132'b0) begin
            bad++;
            $display("FAIL reset_data: addr=%h wdata=%h wstrb=%h want all 0", mem_addr, mem_wdata, mem_wstrb);
        end
    endtask

    task automatic test_if_read();
        exp_t e;
        if_req  = 1'b1;
        if_addr = 32'h0000_0100;
        #1;
        total++;
        if (mem_req !== 1'b0) begin
            bad++;
            $display("FAIL ifrd_idle_req: got %b want 0", mem_req);
        end
        tick();
        #1;
        total++;
        if ({mem_req, mem_we, mem_addr, mem_wstrb} !== {1'b1, 1'b0, 32'h0000_0100, 4'h0}) begin
            bad++;
            $display("FAIL ifrd_req: req=%b we=%b addr=%h wstrb=%h want 1 0 00000100 0",
                     mem_req, mem_we, mem_addr, mem_wstrb);
        end
        mem_ack = 1'b1;
        #1;
        total++;
        if ({if_gnt, d_gnt} !== 2'b10) begin
            bad++;
            $display("FAIL ifrd_gnt: got %b want 10", {if_gnt, d_gnt});
        end
        sb.push_back('{is_d: 1'b0, data: 32'h0000_0013, err: 1'b0});
        tick();
        mem_ack = 1'b0;
        if_req  = 1'b0;
        #1;
        total++;
        if ({mem_req, if_rvalid, busy} !== 3'b001) begin
            bad++;
            $display("FAIL ifrd_wait: req/rvalid/busy=%b want 001", {mem_req, if_rvalid, busy});
        end
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_0013;
        #1;
        e = sb.pop_front();
        total++;
        if ({if_rvalid, if_rdata, if_err, d_rvalid} !== {1'b1, e.data, e.err, 1'b0}) begin
            bad++;
            $display("FAIL ifrd_resp: rvalid=%b rdata=%h err=%b d_rvalid=%b want 1 %h %b 0",
                     if_rvalid, if_rdata, if_err, d_rvalid, e.data, e.err);
        end
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        #1;
        total++;
        if ({busy, if_rvalid} !== 2'b00) begin
            bad++;
            $display("FAIL ifrd_done: busy/rvalid=%b want 00", {busy, if_rvalid});
        end
    endtask

    task automatic test_d_store();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h0000_0200;
        d_wdata = 32'hDEAD_BEEF;
        d_wstrb = 4'hF;
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, d_gnt} !==
                {1'b1, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 4'hF, 1'b0}) begin
                bad++;
                $display("FAIL dst_stall%0d: req=%b we=%b addr=%h wdata=%h wstrb=%h gnt=%b want 1 1 00000200 deadbeef f 0",
                         i, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, d_gnt);
            end
            tick();
        end
        mem_ack = 1'b1;
        #1;
        total++;
        if ({d_gnt, if_gnt, mem_req} !== 3'b101) begin
            bad++;
            $display("FAIL dst_gnt: d_gnt/if_gnt/req=%b want 101", {d_gnt, if_gnt, mem_req});
        end
        tick();
        mem_ack = 1'b0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++;
            if ({busy, mem_req, d_rvalid} !== 3'b000) begin
                bad++;
                $display("FAIL dst_after%0d: busy/req/rvalid=%b want 000", i, {busy, mem_req, d_rvalid});
            end
            tick();
        end
    endtask

    task automatic test_streak();
        int   grants;
        int   resps;
        int   cyc;
        logic in_resp;
        logic exp_d;
        exp_t e;
        if_req  = 1'b1;
        if_addr = 32'h0000_0400;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h0000_0800;
        grants  = 0;
        resps   = 0;
        cyc     = 0;
        in_resp = 1'b0;
        while (resps < 10 && cyc < 200) begin
            tick();
            cyc++;
            mem_ack    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h0;
            if (grants == 10) begin
                d_req  = 1'b0;
                if_req = 1'b0;
            end
            if (in_resp) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 32'hA000_0000 + 32'(resps);
                #1;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL stk_sb_empty: response %0d with nothing expected", resps);
                end else begin
                    e = sb.pop_front();
                    if ({d_rvalid, if_rvalid} !== (e.is_d ? 2'b10 : 2'b01) ||
                        (e.is_d ? d_rdata : if_rdata) !== e.data) begin
                        bad++;
                        $display("FAIL stk_resp%0d: d/if rvalid=%b d_rdata=%h if_rdata=%h want d=%b data=%h",
                                 resps, {d_rvalid, if_rvalid}, d_rdata, if_rdata, e.is_d, e.data);
                    end
                end
                resps++;
                in_resp = 1'b0;
            end else if (mem_req) begin
                mem_ack = 1'b1;
                exp_d   = (grants % 5) != 4;
                #1;
                total++;
                if ({d_gnt, if_gnt} !== (exp_d ? 2'b10 : 2'b01)) begin
                    bad++;
                    $display("FAIL stk_gnt%0d: d/if gnt=%b want %b", grants, {d_gnt, if_gnt},
                             exp_d ? 2'b10 : 2'b01);
                end
                sb.push_back('{is_d: exp_d, data: 32'hA000_0000 + 32'(grants), err: 1'b0});
                grants++;
                in_resp = 1'b1;
            end
        end
        total++;
        if (cyc >= 200) begin
            bad++;
            $display("FAIL stk_timeout: got %0d responses want 10", resps);
        end
        tick();
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        d_req      = 1'b0;
        if_req     = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL stk_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_misaligned();
        exp_t e;
        if_req  = 1'b1;
        if_addr = 32'h0000_0102;
        sb.push_back('{is_d: 1'b0, data: 32'h0, err: 1'b1});
        tick();
        #1;
        e = sb.pop_front();
        total++;
        if ({if_rvalid, if_err, if_rdata, if_gnt, mem_req} !== {1'b1, e.err, e.data, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL mis_err: rvalid=%b err=%b rdata=%h gnt=%b req=%b want 1 1 0 0 0",
                     if_rvalid, if_err, if_rdata, if_gnt, mem_req);
        end
        tick();
        if_req = 1'b0;
        #1;
        total++;
        if ({busy, mem_req, if_rvalid} !== 3'b000) begin
            bad++;
            $display("FAIL mis_done: busy/req/rvalid=%b want 000", {busy, mem_req, if_rvalid});
        end
        if_addr = 32'h0;
    endtask

    task automatic test_timeout();
        exp_t e;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h0000_0300;
        tick();
        mem_ack = 1'b1;
        #1;
        total++;
        if (d_gnt !== 1'b1) begin
            bad++;
            $display("FAIL to_gnt: d_gnt=%b want 1", d_gnt);
        end
        sb.push_back('{is_d: 1'b1, data: 32'h0, err: 1'b1});
        tick();
        mem_ack = 1'b0;
        d_req   = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            #1;
            total++;
            if (k < 16) begin
                if (d_rvalid !== 1'b0) begin
                    bad++;
                    $display("FAIL to_early%0d: d_rvalid=%b want 0", k, d_rvalid);
                end
            end else begin
                e = sb.pop_front();
                if ({d_rvalid, d_err, d_rdata, if_rvalid} !== {1'b1, e.err, e.data, 1'b0}) begin
                    bad++;
                    $display("FAIL to_err: rvalid=%b err=%b rdata=%h if_rvalid=%b want 1 1 0 0",
                             d_rvalid, d_err, d_rdata, if_rvalid);
                end
            end
            tick();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_0055;
        #1;
        total++;
        if ({d_rvalid, if_rvalid, busy} !== 3'b000) begin
            bad++;
            $display("FAIL to_late: d/if rvalid/busy=%b want 000", {d_rvalid, if_rvalid, busy});
        end
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h0000_0500;
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        d_req   = 1'b0;
        tick();
        SYS_reset  = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_0077;
        #1;
        total++;
        if ({d_rvalid, if_rvalid, mem_req} !== 3'b000) begin
            bad++;
            $display("FAIL rst_mid: d/if rvalid/req=%b want 000", {d_rvalid, if_rvalid, mem_req});
        end
        tick();
        SYS_reset = 1'b0;
        #1;
        total++;
        if ({d_rvalid, if_rvalid, d_gnt, if_gnt, mem_req, busy, mem_addr} !== 38'b0) begin
            bad++;
            $display("FAIL rst_after: ctrl=%b addr=%h want 0",
                     {d_rvalid, if_rvalid, d_gnt, if_gnt, mem_req, busy}, mem_addr);
        end
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        if_req     = 1'b1;
        if_addr    = 32'h0000_0104;
        tick();
        mem_ack = 1'b1;
        #1;
        total++;
        if ({mem_req, mem_addr, if_gnt} !== {1'b1, 32'h0000_0104, 1'b1}) begin
            bad++;
            $display("FAIL rst_next_req: req=%b addr=%h gnt=%b want 1 00000104 1", mem_req, mem_addr, if_gnt);
        end
        sb.push_back('{is_d: 1'b0, data: 32'h1234_5678, err: 1'b0});
        tick();
        mem_ack    = 1'b0;
        if_req     = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        #1;
        e = sb.pop_front();
        total++;
        if ({if_rvalid, if_rdata, if_err} !== {1'b1, e.data, e.err}) begin
            bad++;
            $display("FAIL rst_next_resp: rvalid=%b rdata=%h err=%b want 1 %h 0", if_rvalid, if_rdata, if_err, e.data);
        end
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: got %0d entries want 0", sb.size());
        end
    endtask

    initial begin
        SYS_reset  = 1'b1;
        if_req     = 1'b0;
        if_addr    = 32'h0;
        d_req      = 1'b0;
        d_we       = 1'b0;
        d_addr     = 32'h0;
        d_wdata    = 32'h0;
        d_wstrb    = 4'h0;
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        test_reset();
        tick();
        test_if_read();
        test_d_store();
        test_streak();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port main-memory interface between two requesters: instruction fetch (IF, read-only) and data load/store (D).
- Sits between the CPU core and MAIN_MEMORY, so the instruction and data paths can use one RAM port.
- Allows one outstanding transaction at a time. D has priority, with an anti-starvation limit for IF.
- Flags misaligned fetches and memory response timeouts as error responses.

Parameters:
- DATA_STREAK_MAX, 4: max consecutive D grants while if_req is pending before IF is forced to win.
- TIMEOUT_CYCLES, 16: cycles spent in RESP without mem_rvalid before an error response is returned.

Ports:
- SYS_clk  in  1  clock, all state on rising edge.
- SYS_reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request, held until if_gnt or if_rvalid&if_err.
- if_addr  in  32  fetch address, stable while if_req is high.
- if_gnt  out  1  1-cycle pulse: fetch accepted by memory.
- if_rvalid  out  1  1-cycle pulse: fetch data or error valid.
- if_rdata  out  32  fetch data, valid with if_rvalid (0 when if_err).
- if_err  out  1  error qualifier for if_rvalid.
- d_req  in  1  data request, held until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_wstrb  in  4  store byte enables.
- d_gnt  out  1  1-cycle pulse: data request accepted.
- d_rvalid  out  1  1-cycle pulse: load data or error valid.
- d_rdata  out  32  load data.
- d_err  out  1  error qualifier for d_rvalid.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_wstrb  out  4  memory byte enables.
- mem_ack  in  1  memory accepts the request this cycle (may be combinational).
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read data.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: state=IDLE. All outputs 0. Streak counter, timeout counter and owner register cleared.
- States: IDLE, REQ, RESP, ERR.
- IDLE, arbitration:
  - If d_req and (streak < DATA_STREAK_MAX or !if_req): owner=D.
  - Else if if_req: owner=IF.
  - On selection, register addr/we/wdata/wstrb into mem_* registers (IF: we=0, wstrb=0).
  - Go to REQ, except IF with if_addr[1:0]!=0, which goes to ERR with no memory access.
- REQ: mem_req=1 and mem_* held stable.
  - On mem_ack, pulse the owner's gnt the same cycle (combinational from state, owner and mem_ack).
  - Write: go to IDLE. No response phase.
  - Read: go to RESP and clear the timeout counter.
- RESP: mem_req=0.
  - On mem_rvalid, the owner's rvalid=1 and rdata=mem_rdata (combinational pass-through), err=0; go to IDLE.
  - Else increment the timeout counter. At TIMEOUT_CYCLES-1 without rvalid, the owner's rvalid=1 and err=1 with rdata=0; go to IDLE.
- ERR: if_rvalid=1, if_err=1, if_rdata=0 for one cycle, no if_gnt; go to IDLE.
- mem_rvalid outside RESP is ignored. mem_ack outside REQ is ignored.
- Streak counter (saturating):
  - +1 on each D grant while if_req=1.
  - Cleared on an IF grant, an IF ERR, or any IDLE cycle with if_req=0.
- Latency:
  - Request seen in IDLE at cycle N → mem_req at N+1.
  - Minimum read = 3 cycles (IDLE, REQ with ack, RESP with rvalid).
  - Minimum write = 2 cycles.
  - A new arbitration happens in the IDLE cycle after completion. There is no back-to-back issue from RESP.
- Simultaneous d_req and if_req with streak below the limit: D wins, IF keeps if_req asserted.
- The requester dropping req while in REQ/RESP is a protocol violation; the arbiter completes the transaction regardless.
- SYS_reset mid-transaction: next state IDLE, mem_req deasserted, in-flight response discarded, no gnt or rvalid emitted.

Test Plan:
- Single IF read of 0x100, memory acks in REQ, rvalid 2 cycles later with 0x00000013 → mem_req at N+1; if_gnt with ack; if_rvalid=1, if_rdata=0x00000013, if_err=0; busy low after.
- D store to 0x200, wdata=0xDEADBEEF, wstrb=0xF, ack after 3 wait cycles → mem_* stable through the stall; d_gnt pulse; return to IDLE with no d_rvalid.
- if_req and d_req held continuously, D loads only → exactly 4 D grants, then 1 IF grant, repeating pattern D,D,D,D,IF.
- IF at 0x102 → ERR state; if_rvalid=1, if_err=1, if_rdata=0; mem_req never asserted.
- D load acked, mem_rvalid withheld → d_rvalid=1, d_err=1 on the 16th RESP cycle; a late mem_rvalid after that is ignored.
- SYS_reset asserted in RESP, then mem_rvalid arrives → no d_rvalid; all outputs 0; next request arbitrates normally.
